posit_weight_serializer: RTL

- Transmit side of the bit-serial posit weight interface consumed by fp_posit_mul.
- Accepts parallel posit weight words from the weight buffer into a small FIFO.
- Shifts each word out MSB-first, one bit per clock, on w/valid at the programmed precision.
- Marks word boundaries so the multiplier's done/start_acc cadence can be checked against them.

---
 rtl/fp_posit_pkg.sv | 16 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/posit_weight_serializer.sv | 102 ++++++++++
 3 files changed

// File: rtl/fp_posit_pkg.sv
// rtl/fp_posit_pkg.sv - shared constants, state encoding and precision clamp for the posit weight path
package fp_posit_pkg;

    localparam int PREC_MIN = 2;
    localparam int PREC_W   = 4;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p,
                                                     input logic [PREC_W-1:0] pmax);
        if (p < PREC_W'(PREC_MIN)) return PREC_W'(PREC_MIN);
        if (p > pmax) return pmax;
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO holding parallel weight words
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/posit_weight_serializer.sv
// rtl/posit_weight_serializer.sv - buffers parallel posit weights and shifts them out MSB-first, one bit per clock
module posit_weight_serializer
    import fp_posit_pkg::*;
#(
    parameter int MAX_PREC = 8,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PREC_W-1:0]   precision,
    input  logic                set,
    input  logic [MAX_PREC-1:0] w_in,
    input  logic                w_in_valid,
    output logic                w_in_ready,
    input  logic                hold,
    output logic                w,
    output logic                valid,
    output logic                word_start,
    output logic                word_last,
    output logic                busy,
    output logic                set_err
);

    localparam int                CW   = $clog2(DEPTH) + 1;
    localparam logic [PREC_W-1:0] PMAX = PREC_W'(MAX_PREC);

    state_t              state;
    logic [MAX_PREC-1:0] sreg;
    logic [MAX_PREC-1:0] head;
    logic [MAX_PREC-1:0] loaded;
    logic [PREC_W-1:0]   bcnt;
    logic [PREC_W-1:0]   n;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    sync_fifo #(
        .WIDTH (MAX_PREC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (w_in),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign w_in_ready = !full;
    assign push       = w_in_valid && w_in_ready;
    assign busy       = (count != '0) || (state == S_SHIFT);
    // hold also defers the first pop out of IDLE, so a stalled consumer lets the FIFO fill.
    assign pop        = !empty && !hold && ((state == S_IDLE) || (bcnt == '0));
    assign loaded     = head << (PMAX - n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sreg       <= '0;
            bcnt       <= '0;
            n          <= PREC_W'(4);
            set_err    <= 1'b0;
            w          <= 1'b0;
            valid      <= 1'b0;
            word_start <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            if (set) begin
                if (busy) set_err <= 1'b1;
                else      n       <= clamp_prec(precision, PMAX);
            end
            if (pop) begin
                state      <= S_SHIFT;
                sreg       <= loaded;
                bcnt       <= n - 1'b1;
                w          <= loaded[MAX_PREC-1];
                valid      <= 1'b1;
                word_start <= 1'b1;
                word_last  <= 1'b0;
            end else if (state == S_SHIFT && !hold) begin
                sreg       <= sreg << 1;
                word_start <= 1'b0;
                if (bcnt == '0) begin
                    state     <= S_IDLE;
                    w         <= 1'b0;
                    valid     <= 1'b0;
                    word_last <= 1'b0;
                end else begin
                    bcnt      <= bcnt - 1'b1;
                    w         <= sreg[MAX_PREC-2];
                    word_last <= (bcnt == PREC_W'(1));
                end
            end
        end
    end

endmodule
